// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the parallel memory bus initiator.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    TURN   = 2'd3
  } bus_state_t;

  localparam int MEM_ADDR_W   = 16;
  localparam int MEM_DATA_W   = 8;
  localparam int MEM_WAIT_MAX = 15;

endpackage

// File: rtl/mem_bus_master.sv
// Single-beat bus initiator: address setup, strobe phase of WAIT_CYCLES clocks,
// one turnaround cycle carrying the response pulse.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              wr_en,
  output logic              rd_en,
  output logic              rom_enable,
  output logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > MEM_WAIT_MAX) begin : g_bad_wait
    $error("mem_bus_master: WAIT_CYCLES must be within 1..15");
  end

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  bus_state_t        state;
  bus_state_t        state_nxt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        wait_cnt;
  logic              bus_drive;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The request is latched on acceptance so the core may change its inputs
  // while the transfer is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_cnt <= 4'd0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == SETUP) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == STROBE && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == STROBE && wait_cnt == 4'd0 && !we_q) begin
        rdata_q <= data_bus;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    rom_enable = 1'b1;
    bus_drive  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
      end
      STROBE: begin
        rom_enable = 1'b0;
        rd_en      = ~we_q;
        wr_en      = we_q;
        bus_drive  = we_q;
        if (wait_cnt == 4'd0) begin
          state_nxt = TURN;
        end
      end
      TURN: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Address stays on the bus after a transfer; it only changes on acceptance.
  assign address_bus = addr_q;
  assign rsp_rdata   = rdata_q;
  assign data_bus    = bus_drive ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: W=2 instance with a ROM responder,
// plus W=1 and W=15 instances; released data bus reads 0xFF via tri1.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid_v = 3'b000;
  logic        req_we      = 1'b0;
  logic [15:0] req_addr    = 16'h0000;
  logic [7:0]  req_wdata   = 8'h00;

  logic [2:0]  req_ready_v, rsp_valid_v, busy_v, wr_en_v, rd_en_v, rom_enable_v;
  logic [15:0] address_bus_v [3];
  logic [7:0]  rsp_rdata_v [3];
  logic [7:0]  bus_v [3];
  tri1  [7:0]  data_bus0, data_bus1, data_bus2;

  logic [7:0]  rom_mem [0:65535];
  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  mem_bus_master #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[0]), .rsp_rdata(rsp_rdata_v[0]), .busy(busy_v[0]),
    .wr_en(wr_en_v[0]), .rd_en(rd_en_v[0]), .rom_enable(rom_enable_v[0]),
    .address_bus(address_bus_v[0]), .data_bus(data_bus0));

  mem_bus_master #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[1]), .rsp_rdata(rsp_rdata_v[1]), .busy(busy_v[1]),
    .wr_en(wr_en_v[1]), .rd_en(rd_en_v[1]), .rom_enable(rom_enable_v[1]),
    .address_bus(address_bus_v[1]), .data_bus(data_bus1));

  mem_bus_master #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(15)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[2]), .rsp_rdata(rsp_rdata_v[2]), .busy(busy_v[2]),
    .wr_en(wr_en_v[2]), .rd_en(rd_en_v[2]), .rom_enable(rom_enable_v[2]),
    .address_bus(address_bus_v[2]), .data_bus(data_bus2));

  assign bus_v[0] = data_bus0;
  assign bus_v[1] = data_bus1;
  assign bus_v[2] = data_bus2;

  // ROM responder on the W=2 bus: drives only during a selected read strobe.
  assign data_bus0 = (!rom_enable_v[0] && rd_en_v[0]) ? rom_mem[address_bus_v[0]] : 8'hzz;
  always @(posedge clk) begin
    if (!rom_enable_v[0] && wr_en_v[0]) rom_mem[address_bus_v[0]] <= data_bus0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus invariants, checked every cycle on every instance.
  task automatic checkBus(input string tag, input logic cs_n, input logic rd,
                          input logic wr, input logic [7:0] bus);
    checkOutput({tag, "_excl"}, {31'd0, rd && wr}, 32'd0);
    checkOutput({tag, "_cs"}, {31'd0, cs_n && (rd || wr)}, 32'd0);
    if (!rd && !wr) checkOutput({tag, "_release"}, {24'd0, bus}, 32'hff);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checkBus("mon0", rom_enable_v[0], rd_en_v[0], wr_en_v[0], data_bus0);
      checkBus("mon1", rom_enable_v[1], rd_en_v[1], wr_en_v[1], data_bus1);
      checkBus("mon2", rom_enable_v[2], rd_en_v[2], wr_en_v[2], data_bus2);
    end
  end

  // Presents a request to instance s and returns in its SETUP cycle.
  task automatic applyStimulus(input int s, input logic we, input logic [15:0] addr,
                               input logic [7:0] wdata);
    int n = 0;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_valid_v[s] = 1'b1;
    while (!req_ready_v[s] && n < 20) begin
      tick();
      n++;
    end
    checkOutput("accept_wait", {31'd0, n < 20}, 32'd1);
    tick();
    req_valid_v[s] = 1'b0;
  endtask

  // From the SETUP cycle, follows a transfer to its response and back to IDLE.
  task automatic followTransfer(input int s, input string tag, input logic we,
                                input logic [7:0] exp_data, input int w);
    int cyc = 1;
    int strobes = 0;
    bit seen = 1'b0;
    checkOutput({tag, "_setup_cs"}, {31'd0, rom_enable_v[s]}, 32'd1);
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (rd_en_v[s] || wr_en_v[s]) begin
        strobes++;
        checkOutput({tag, "_dir"}, {31'd0, wr_en_v[s]}, {31'd0, we});
        checkOutput({tag, "_bus"}, {24'd0, bus_v[s]}, {24'd0, exp_data});
      end
      if (rsp_valid_v[s]) seen = 1'b1;
    end
    checkOutput({tag, "_rsp"}, {31'd0, seen}, 32'd1);
    checkOutput({tag, "_lat"}, cyc, w + 2);
    checkOutput({tag, "_strobes"}, strobes, w);
    if (!we) checkOutput({tag, "_rdata"}, {24'd0, rsp_rdata_v[s]}, {24'd0, exp_data});
    tick();
    checkOutput({tag, "_idle"}, {31'd0, req_ready_v[s]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) rom_mem[i] = 8'h00;
    tick();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_ready", {31'd0, req_ready_v[0]}, 32'd1);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid_v[0]}, 32'd0);
    checkOutput("rst_rdata", {24'd0, rsp_rdata_v[0]}, 32'h00);
    checkOutput("rst_busy", {31'd0, busy_v[0]}, 32'd0);
    checkOutput("rst_wr", {31'd0, wr_en_v[0]}, 32'd0);
    checkOutput("rst_rd", {31'd0, rd_en_v[0]}, 32'd0);
    checkOutput("rst_cs", {31'd0, rom_enable_v[0]}, 32'd1);
    checkOutput("rst_addr", {16'd0, address_bus_v[0]}, 32'h0000);
    checkOutput("rst_bus", {24'd0, data_bus0}, 32'hff);
    mon_en = 1'b1;

    // Write 0xAA to 0x0001, cycle by cycle
    applyStimulus(0, 1'b1, 16'h0001, 8'hAA);
    checkOutput("t1_setup_addr", {16'd0, address_bus_v[0]}, 32'h0001);
    checkOutput("t1_setup_cs", {31'd0, rom_enable_v[0]}, 32'd1);
    checkOutput("t1_setup_wr", {31'd0, wr_en_v[0]}, 32'd0);
    checkOutput("t1_setup_bus", {24'd0, data_bus0}, 32'hff);
    checkOutput("t1_setup_busy", {31'd0, busy_v[0]}, 32'd1);
    checkOutput("t1_setup_ready", {31'd0, req_ready_v[0]}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("t1_strobe_wr", {31'd0, wr_en_v[0]}, 32'd1);
      checkOutput("t1_strobe_rd", {31'd0, rd_en_v[0]}, 32'd0);
      checkOutput("t1_strobe_cs", {31'd0, rom_enable_v[0]}, 32'd0);
      checkOutput("t1_strobe_bus", {24'd0, data_bus0}, 32'haa);
      checkOutput("t1_strobe_rsp", {31'd0, rsp_valid_v[0]}, 32'd0);
    end
    tick();
    checkOutput("t1_turn_rsp", {31'd0, rsp_valid_v[0]}, 32'd1);
    checkOutput("t1_turn_wr", {31'd0, wr_en_v[0]}, 32'd0);
    checkOutput("t1_turn_cs", {31'd0, rom_enable_v[0]}, 32'd1);
    checkOutput("t1_turn_addr", {16'd0, address_bus_v[0]}, 32'h0001);
    tick();
    checkOutput("t1_idle_rsp", {31'd0, rsp_valid_v[0]}, 32'd0);
    checkOutput("t1_idle_ready", {31'd0, req_ready_v[0]}, 32'd1);
    checkOutput("t1_idle_busy", {31'd0, busy_v[0]}, 32'd0);
    checkOutput("t1_idle_addr", {16'd0, address_bus_v[0]}, 32'h0001);

    // Write 0xBB to 0x13C4, read both back; stale write data 0x55 must stay off the bus
    applyStimulus(0, 1'b1, 16'h13C4, 8'hBB);
    followTransfer(0, "t2_wr", 1'b1, 8'hBB, 2);
    applyStimulus(0, 1'b0, 16'h0001, 8'h55);
    followTransfer(0, "t2_rd1", 1'b0, 8'hAA, 2);
    applyStimulus(0, 1'b0, 16'h13C4, 8'h55);
    followTransfer(0, "t2_rd2", 1'b0, 8'hBB, 2);

    // Back-to-back reads with req_valid held: accepted every 5 cycles
    req_we = 1'b0;
    req_addr = 16'h13C4;
    req_valid_v[0] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      checkOutput("t3_ready", {31'd0, req_ready_v[0]}, {31'd0, (c % 5) == 0});
      checkOutput("t3_rsp", {31'd0, rsp_valid_v[0]}, {31'd0, (c % 5) == 4});
      if ((c % 5) == 4) checkOutput("t3_rdata", {24'd0, rsp_rdata_v[0]}, 32'hbb);
      tick();
    end
    req_valid_v[0] = 1'b0;

    // Reset in the second strobe cycle of a write; req_valid during reset is ignored
    applyStimulus(0, 1'b1, 16'h0001, 8'h55);
    tick();
    tick();
    checkOutput("t4_pre_wr", {31'd0, wr_en_v[0]}, 32'd1);
    rst = 1'b1;
    req_valid_v[0] = 1'b1;
    tick();
    checkOutput("t4_wr", {31'd0, wr_en_v[0]}, 32'd0);
    checkOutput("t4_rd", {31'd0, rd_en_v[0]}, 32'd0);
    checkOutput("t4_cs", {31'd0, rom_enable_v[0]}, 32'd1);
    checkOutput("t4_bus", {24'd0, data_bus0}, 32'hff);
    checkOutput("t4_rsp", {31'd0, rsp_valid_v[0]}, 32'd0);
    checkOutput("t4_busy", {31'd0, busy_v[0]}, 32'd0);
    checkOutput("t4_addr", {16'd0, address_bus_v[0]}, 32'h0000);
    tick();
    checkOutput("t4_rst_busy", {31'd0, busy_v[0]}, 32'd0);
    rst = 1'b0;
    req_valid_v[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("t4_no_rsp", {31'd0, rsp_valid_v[0]}, 32'd0);
    end

    // Request inputs change during STROBE; the latched transfer completes
    applyStimulus(0, 1'b1, 16'h0200, 8'h3C);
    for (int i = 0; i < 2; i++) begin
      tick();
      req_addr = 16'hFFFF;
      req_wdata = 8'h00;
      req_we = 1'b0;
      checkOutput("t5_addr", {16'd0, address_bus_v[0]}, 32'h0200);
      checkOutput("t5_bus", {24'd0, data_bus0}, 32'h3c);
      checkOutput("t5_wr", {31'd0, wr_en_v[0]}, 32'd1);
    end
    tick();
    checkOutput("t5_rsp", {31'd0, rsp_valid_v[0]}, 32'd1);
    tick();
    applyStimulus(0, 1'b0, 16'h0200, 8'h81);
    followTransfer(0, "t5_rd", 1'b0, 8'h3C, 2);

    // Strobe length at the WAIT_CYCLES extremes
    applyStimulus(1, 1'b1, 16'h0040, 8'h5A);
    followTransfer(1, "t6_w1_wr", 1'b1, 8'h5A, 1);
    applyStimulus(1, 1'b0, 16'h0040, 8'h00);
    followTransfer(1, "t6_w1_rd", 1'b0, 8'hFF, 1);
    applyStimulus(2, 1'b1, 16'h0040, 8'hA5);
    followTransfer(2, "t6_w15_wr", 1'b1, 8'hA5, 15);

    tick();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus initiator that drives the 8-bit/16-bit parallel memory bus on which the on-chip ROM is a responder. It accepts single-beat read/write requests from the core over a valid/ready handshake. It sequences address setup, the strobe phase (`rom_enable` low plus `rd_en` or `wr_en`) and bus turnaround, then returns a one-cycle response carrying read data or a write acknowledge. Writes target the ROM's simulation-only write path.

## Interface
Parameters:
- `ADDR_W`, 16: address bus width.
- `DATA_W`, 8: data bus width.
- `WAIT_CYCLES`, 2: strobe-phase length in clocks; legal range 1..15, otherwise elaboration error.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  request address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle response pulse, for reads and writes.
- `rsp_rdata`  out  DATA_W  read data; holds its last value when `rsp_valid` is low.
- `busy`  out  1  high in any state other than IDLE.
- `wr_en`  out  1  bus write strobe.
- `rd_en`  out  1  bus read strobe.
- `rom_enable`  out  1  active-low chip select; 1 = deselected.
- `address_bus`  out  ADDR_W  bus address.
- `data_bus`  inout  DATA_W  bidirectional data; high-Z except when the master drives it during a write.

## Operation
- FSM states are IDLE, SETUP, STROBE and TURN.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch `req_we`, `req_addr` and `req_wdata`, then go to SETUP.
- **SETUP** (1 cycle)
  - `address_bus` = latched address.
  - `rom_enable` = 1; both strobes 0; `data_bus` high-Z.
  - Load the wait counter with `WAIT_CYCLES-1`. Next state is STROBE.
- **STROBE** (`WAIT_CYCLES` cycles)
  - `rom_enable` = 0.
  - `rd_en` = ~we and `wr_en` = we.
  - Writes drive `data_bus` with the latched data for the whole phase; reads leave it high-Z.
  - The counter decrements each cycle. At 0, a read captures `data_bus` into `rsp_rdata` on that edge, and the next state is TURN.
- **TURN** (1 cycle)
  - Both strobes 0, `rom_enable` = 1, `data_bus` high-Z.
  - `address_bus` holds the latched address.
  - `rsp_valid` = 1. Next state is IDLE.
- `address_bus` holds the last address in IDLE; it does not return to 0.
- Invariants:
  - `wr_en && rd_en` is never true.
  - Neither strobe is asserted while `rom_enable` = 1.
  - `data_bus` is driven only in STROBE with we = 1.
- Request inputs are ignored outside IDLE. No queuing; the core must hold its request until `req_ready`.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `busy`=0, `wr_en`=0, `rd_en`=0, `rom_enable`=1, `address_bus`=0, `data_bus` high-Z, state IDLE.
- Latency: the request is accepted on edge N. The FSM is in SETUP during cycle N+1 and in STROBE during cycles N+2..N+1+W. `rsp_valid` is high in cycle N+2+W.
- Throughput: one transfer per W+3 cycles; a back-to-back request is accepted in the IDLE cycle after TURN.
- Reset mid-operation (any state): on the next edge all strobes drop, `rom_enable`=1, the bus is released and the FSM returns to IDLE. The response is dropped and `rsp_valid` stays 0.
- `req_valid` asserted during reset is not accepted, because `rst` has priority.
- With W=1 the counter is loaded with 0 and STROBE lasts exactly one cycle.

## Structure
- Package `mem_bus_pkg` holds:
  - the state enum (IDLE/SETUP/STROBE/TURN);
  - `MEM_ADDR_W`=16 and `MEM_DATA_W`=8, used as the parameter defaults;
  - the `WAIT_CYCLES` max constant.
- No sub-module. The FSM, the 4-bit wait counter and the tri-state assign are all in one module.

## Test plan
All scenarios use the bench ROM responder with W=2.
1. Write 0xAA to 0x0001:
   - `wr_en`=1 and `rom_enable`=0 for exactly 2 cycles with `data_bus`=0xAA.
   - `rsp_valid` pulses in cycle N+4.
2. Write 0xBB to 0x13C4, then read 0x0001 and 0x13C4:
   - `rsp_rdata` = 0xAA then 0xBB.
   - `rd_en` is high 2 cycles per read and `data_bus` is never driven by the master during reads.
3. Hold `req_valid` continuously for 3 reads: `req_ready` is high only in IDLE, and transfers are accepted every 5 cycles.
4. Assert `rst` in the second STROBE cycle of a write to 0x0001:
   - Next cycle: strobes 0, `rom_enable`=1, `data_bus`=Z.
   - No `rsp_valid` follows.
5. Change `req_addr`/`req_wdata` during STROBE: the bus values are unchanged and the latched request completes.
6. Run with W=1 and W=15: STROBE lasts 1 and 15 cycles respectively, and a bus-monitor assertion checks the strobe invariants on every cycle.
